storage_fifo_ctrl: RTL and testbench
====================================

// Module: storage_fifo_ctrl
// PURPOSE
//   Initiator-side controller for the flip-flop storage array: drives its wr_en/wr_addrs/wr_data and
//   rd_en/rd_addrs ports and consumes its combinational rd_data, presenting the array as a FIFO.
//   Upstream pushes and downstream pops use valid/ready handshakes.
//   Contains one registered output stage; total capacity = DEPTH + 1 words.
// PARAMETERS
//   WIDTH     1024      data word width; must match the attached storage
//   DEPTH     512       storage entries; power of two, >= 2
//   AF_LEVEL  DEPTH-2   almost_full asserts when count >= AF_LEVEL
// PORTS
//   clk            in   1                  clock; all state updates on posedge
//   rst_n          in   1                  asynchronous reset, active low
//   flush          in   1                  synchronous clear of all contents, single cycle
//   push_valid     in   1                  upstream word valid
//   push_ready     out  1                  controller can accept a word
//   push_data      in   WIDTH              upstream word
//   pop_valid      out  1                  output register holds a word
//   pop_ready      in   1                  downstream accepts the word
//   pop_data       out  WIDTH              output register contents
//   count          out  $clog2(DEPTH)+1    words held, storage plus output register
//   almost_full    out  1                  count >= AF_LEVEL
//   st_wr_en       out  1                  storage write enable
//   st_wr_addrs    out  $clog2(DEPTH)      storage write address
//   st_wr_data     out  WIDTH              storage write data
//   st_rd_en       out  1                  storage read enable
//   st_rd_addrs    out  $clog2(DEPTH)      storage read address
//   st_rd_data     in   WIDTH              storage read data, combinational from st_rd_addrs
// BEHAVIOUR
//   - Reset (rst_n low, async) clears wr_ptr, rd_ptr, st_cnt, out_vld and pop_data to 0.
//     After reset: pop_valid=0, count=0, push_ready=1, almost_full=0, all st_* enables 0.
//   - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//     st_cnt (0..DEPTH) tracks the number of storage entries.
//   - push_ready = (st_cnt != DEPTH) && !flush. push fire = push_valid && push_ready.
//   - Write path, combinational on push fire: st_wr_en=1, st_wr_addrs=wr_ptr, st_wr_data=push_data.
//     wr_ptr increments at the edge.
//   - Output stage has two states, EMPTY (out_vld=0) and FULL (out_vld=1). pop_valid = out_vld.
//     pop fire = pop_valid && pop_ready.
//   - Prefetch: st_rd_en = (st_cnt != 0) && (!out_vld || pop_ready) && !flush; st_rd_addrs = rd_ptr.
//     On st_rd_en: pop_data <= st_rd_data, out_vld <= 1, rd_ptr increments.
//     A pop fire with no prefetch sets out_vld <= 0. pop_data holds its value when not reloaded.
//   - st_cnt next = st_cnt + push_fire - st_rd_en. count = st_cnt + out_vld.
//     All outputs are combinational from registers plus current handshake inputs.
//   - Latency: a word pushed into an empty controller is accepted at edge N and shows pop_valid=1
//     after edge N+1, i.e. 2 cycles.
//   - Throughput: once primed, simultaneous push and pop sustain 1 word/cycle.
//   - Read and write never target the same entry in the same cycle: a read needs st_cnt != 0 from
//     the registered count, and a push needs st_cnt != DEPTH.
//   - Full: st_cnt=DEPTH drops push_ready; a pop frees one slot, and push_ready is high the next cycle.
//   - flush=1: pushes and prefetch are blocked that cycle. At the edge, pointers, st_cnt and out_vld
//     go to 0; pop_data is left unchanged. A pop fire in the same cycle is still delivered, then
//     discarded from state.
//   - Ordering is strictly FIFO; no word is duplicated or dropped except by flush or reset.
//   - Storage contents are never cleared by this block; validity is tracked only by the pointers.
// TESTING (DEPTH=4, WIDTH=8)
//   1. Release reset, idle -> pop_valid=0, count=0, push_ready=1, st_wr_en=0, st_rd_en=0.
//   2. Push 0xA1 with pop_ready=0 -> pop_valid=1 two cycles later, pop_data=0xA1, count=1.
//   3. pop_ready=0, push 0x01..0x06 -> 5 accepted, push_ready=0 when count=5;
//      almost_full high from count=2; pop all -> 0x01..0x05 in order.
//   4. Prime 2 words, then push and pop every cycle for 12 cycles -> one pop per cycle, values in
//      order, pointers wrap 3->0 with no loss.
//   5. Hold 3 words, pulse flush -> count=0, pop_valid=0 next cycle; a following push of 0x7E
//      pops as 0x7E.
//   6. Assert rst_n low mid-stream while push and pop are active -> all outputs return to their
//      reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/storage_fifo_ctrl.sv
// storage_fifo_ctrl
//   Makes an external flip-flop storage array behave as a FIFO. The controller
//   drives the array's write and read ports. The array returns rd_data
//   combinationally from the read address.
//   One registered output stage sits in front of the pop port, so the total
//   capacity is DEPTH + 1 words.
//
// Ports
//   clk, rst_n          clock and asynchronous active-low reset
//   flush               synchronous single-cycle clear of all held words
//   push_valid/ready    upstream handshake, push_data carries the word
//   pop_valid/ready     downstream handshake, pop_data is the output register
//   count               words held (storage + output register)
//   almost_full         count >= AF_LEVEL
//   st_wr_en/addrs/data write port toward the storage array
//   st_rd_en/addrs      read port toward the storage array
//   st_rd_data          combinational read data from the storage array
//
// Output stage states
//   state | meaning
//   EMPTY | output register holds no word, pop_valid low
//   FULL  | output register holds the head word, pop_valid high
module storage_fifo_ctrl #(
  parameter int WIDTH    = 1024,
  parameter int DEPTH    = 512,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       st_wr_en,
  output logic [$clog2(DEPTH)-1:0]   st_wr_addrs,
  output logic [WIDTH-1:0]           st_wr_data,
  output logic                       st_rd_en,
  output logic [$clog2(DEPTH)-1:0]   st_rd_addrs,
  input  logic [WIDTH-1:0]           st_rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  out_state_t      state_q;
  out_state_t      state_d;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   st_cnt;
  logic            out_vld;
  logic            push_fire;
  logic            pop_fire;

  assign push_ready = (st_cnt != FULL_CNT) && !flush;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = out_vld && pop_ready;

  // Prefetch whenever the output register is empty or being drained this cycle.
  // The read uses the registered st_cnt, so it never targets the slot being written.
  assign st_rd_en    = (st_cnt != '0) && (!out_vld || pop_ready) && !flush;
  assign st_rd_addrs = rd_ptr;

  assign st_wr_en    = push_fire;
  assign st_wr_addrs = wr_ptr;
  assign st_wr_data  = push_data;

  assign count       = st_cnt + CW'(out_vld);
  assign almost_full = (count >= AF_CNT);

  // Output stage: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output stage: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (st_rd_en) begin
      state_d = FULL;
    end else if (pop_fire) begin
      state_d = EMPTY;
    end
  end

  // Output stage: outputs
  always_comb begin
    out_vld   = (state_q == FULL);
    pop_valid = out_vld;
  end

  // Pointers, storage occupancy and output register.
  // A flush leaves pop_data untouched; validity lives only in the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      st_cnt   <= '0;
      pop_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      st_cnt <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (st_rd_en) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pop_data <= st_rd_data;
      end
      case ({push_fire, st_rd_en})
        2'b10:   st_cnt <= st_cnt + 1'b1;
        2'b01:   st_cnt <= st_cnt - 1'b1;
        default: st_cnt <= st_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_storage_fifo_ctrl.sv
// Bench for storage_fifo_ctrl with a small storage array (DEPTH=4, WIDTH=8).
// The array is modelled here: writes are clocked and reads are combinational.
// The driver queues every accepted word. The monitor checks each delivered
// word against that queue and checks the occupancy outputs against an
// occupancy model.
module tb_storage_fifo_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CW    = 3;
  localparam int AF    = DEPTH - 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             push_valid = 1'b0;
  logic             pop_ready = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic             push_ready, pop_valid, almost_full, st_wr_en, st_rd_en;
  logic [WIDTH-1:0] pop_data, st_wr_data, st_rd_data;
  logic [CW-1:0]    count;
  logic [AW-1:0]    st_wr_addrs, st_rd_addrs;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int m_sto = 0;   // words in storage
  int m_out = 0;   // words in output register (0/1)

  storage_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count), .almost_full(almost_full),
    .st_wr_en(st_wr_en), .st_wr_addrs(st_wr_addrs), .st_wr_data(st_wr_data),
    .st_rd_en(st_rd_en), .st_rd_addrs(st_rd_addrs), .st_rd_data(st_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (st_wr_en) mem[st_wr_addrs] <= st_wr_data;
  assign st_rd_data = mem[st_rd_addrs];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, when inputs are stable.
  always @(negedge clk) begin : monitor
    bit pf, popf, rd;
    logic [WIDTH-1:0] e;
    if (!rst_n) begin
      m_sto = 0;
      m_out = 0;
    end else begin
      pf   = push_valid && (m_sto < DEPTH) && !flush;
      popf = (m_out == 1) && pop_ready;
      rd   = (m_sto > 0) && ((m_out == 0) || pop_ready) && !flush;
      chk("count", int'(count), m_sto + m_out);
      chk("pop_valid", int'(pop_valid), m_out);
      chk("push_ready", int'(push_ready), int'((m_sto < DEPTH) && !flush));
      chk("almost_full", int'(almost_full), int'((m_sto + m_out) >= AF));
      chk("st_wr_en", int'(st_wr_en), int'(pf));
      chk("st_rd_en", int'(st_rd_en), int'(rd));
      if (pop_valid && pop_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk("pop_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", int'(pop_data), int'(e));
        end
      end
      if (flush) exp_q.delete();
      if (flush) begin
        m_sto = 0;
        m_out = 0;
      end else begin
        m_sto = m_sto + int'(pf) - int'(rd);
        if (rd) m_out = 1;
        else if (popf) m_out = 0;
      end
    end
  end

  task automatic drive(input bit pv, input logic [WIDTH-1:0] d, input bit pr, input bit fl);
    @(posedge clk);
    #1;
    push_valid = pv;
    push_data  = d;
    pop_ready  = pr;
    flush      = fl;
    #1;
    if (rst_n && push_valid && push_ready) exp_q.push_back(d);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
    idle();
    #1;
    chk("drain_count", int'(count), 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    int p0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #12 rst_n = 1'b1;

    // 1: idle after reset
    idle();
    #1;
    chk("rst_pop_valid", int'(pop_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_push_ready", int'(push_ready), 1);
    chk("rst_st_wr_en", int'(st_wr_en), 0);
    chk("rst_st_rd_en", int'(st_rd_en), 0);

    // 2: two-cycle latency
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    idle();
    #1;
    chk("lat_pop_valid_n", int'(pop_valid), 0);
    idle();
    #1;
    chk("lat_pop_valid_n1", int'(pop_valid), 1);
    chk("lat_pop_data", int'(pop_data), 8'hA1);
    chk("lat_count", int'(count), 1);
    drain();

    // 3: fill to capacity, then drain in order
    for (int i = 1; i <= 6; i++) drive(1'b1, WIDTH'(i), 1'b0, 1'b0);
    #1;
    chk("full_push_ready", int'(push_ready), 0);
    chk("full_count", int'(count), DEPTH + 1);
    chk("full_accepted", exp_q.size(), DEPTH + 1);
    p0 = pops;
    drain();
    chk("full_pops", pops - p0, DEPTH + 1);

    // 4: streaming at one word per cycle through pointer wrap
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    idle();
    idle();
    p0 = pops;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, WIDTH'(8'h20 + i), 1'b1, 1'b0);
      #1;
      chk("stream_pop_valid", int'(pop_valid), 1);
      chk("stream_push_ready", int'(push_ready), 1);
    end
    idle();
    chk("stream_pops", pops - p0, 12);
    drain();

    // 5: flush with three words held
    for (int i = 0; i < 3; i++) drive(1'b1, WIDTH'(8'h50 + i), 1'b0, 1'b0);
    idle();
    idle();
    #1;
    chk("pre_flush_count", int'(count), 3);
    drive(1'b0, '0, 1'b0, 1'b1);
    idle();
    #1;
    chk("flush_count", int'(count), 0);
    chk("flush_pop_valid", int'(pop_valid), 0);
    drive(1'b1, 8'h7E, 1'b0, 1'b0);
    idle();
    idle();
    #1;
    chk("post_flush_data", int'(pop_data), 8'h7E);
    drain();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), WIDTH'($urandom_range(0, 255)),
            bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 39) == 0));
    end
    drain();

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) drive(1'b1, WIDTH'($urandom_range(0, 255)), bit'(i > 2), 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_pop_valid", int'(pop_valid), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_push_ready", int'(push_ready), 1);
    chk("arst_almost_full", int'(almost_full), 0);
    chk("arst_st_rd_en", int'(st_rd_en), 0);
    chk("arst_pop_data", int'(pop_data), 0);
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    #1;
    chk("post_rst_count", int'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
